// File: rtl/vektor_carpim_hizlandirici.sv
// Dot-product engine: buffers X/W vectors, multiplies SERIT pairs per cycle
// through a fixed-latency pipeline and accumulates speculatively until RUN.
module vektor_carpim_hizlandirici #(
  parameter int unsigned VERI_BIT        = 32,
  parameter int unsigned DERINLIK        = 16,
  parameter int unsigned SERIT           = 2,
  parameter int unsigned CARPICI_GECIKME = 3,
  parameter int unsigned DOYUM           = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                islem_gecerli_i,
  output logic                islem_hazir_o,
  input  logic [2:0]          islem_kod_i,
  input  logic                isaretli_i,
  input  logic [VERI_BIT-1:0] islec1_i,
  input  logic [VERI_BIT-1:0] islec2_i,
  output logic [VERI_BIT-1:0] sonuc_o,
  output logic                sonuc_gecerli_o,
  output logic                tasma_o
);

  localparam int unsigned SAYAC_BIT  = $clog2(DERINLIK + 1);
  localparam int unsigned ACC_BIT    = 2 * VERI_BIT + $clog2(DERINLIK) + 1;
  localparam int unsigned IDX_BIT    = $clog2(DERINLIK);
  localparam int unsigned CARPIM_BIT = 2 * VERI_BIT + 2;

  localparam logic [2:0] KOD_LDX_OP1 = 3'd0;
  localparam logic [2:0] KOD_LDX_ALL = 3'd1;
  localparam logic [2:0] KOD_LDW_OP1 = 3'd2;
  localparam logic [2:0] KOD_LDW_ALL = 3'd3;
  localparam logic [2:0] KOD_CLRX    = 3'd4;
  localparam logic [2:0] KOD_CLRW    = 3'd5;
  localparam logic [2:0] KOD_RUN     = 3'd6;

  localparam logic signed [ACC_BIT-1:0] S_MAX =
    {{(ACC_BIT-VERI_BIT+1){1'b0}}, {(VERI_BIT-1){1'b1}}};
  localparam logic signed [ACC_BIT-1:0] S_MIN =
    {{(ACC_BIT-VERI_BIT+1){1'b1}}, {(VERI_BIT-1){1'b0}}};
  localparam logic signed [ACC_BIT-1:0] U_MAX =
    {{(ACC_BIT-VERI_BIT){1'b0}}, {VERI_BIT{1'b1}}};

  localparam logic [SAYAC_BIT-1:0] DOLU     = SAYAC_BIT'(DERINLIK);
  localparam logic [SAYAC_BIT-1:0] BIR_EKSIK = SAYAC_BIT'(DERINLIK - 1);
  localparam logic [SAYAC_BIT-1:0] SERIT_S  = SAYAC_BIT'(SERIT);

  logic [VERI_BIT-1:0]       buf_x [DERINLIK];
  logic [VERI_BIT-1:0]       buf_w [DERINLIK];
  logic [SAYAC_BIT-1:0]      count_x, count_w, istek, sonuc_say;
  logic                      isaretli_mod;
  logic signed [ACC_BIT-1:0] acc;

  logic [CARPICI_GECIKME-1:0] pipe_gecerli;
  logic signed [ACC_BIT-1:0]  pipe_toplam [CARPICI_GECIKME];
  logic [SAYAC_BIT-1:0]       pipe_k [CARPICI_GECIKME];

  logic                       kabul_c, clr_kabul_c;
  logic [SAYAC_BIT-1:0]       min_c, kalan_c, k_c;
  logic [IDX_BIT-1:0]         okuma_idx;
  logic [VERI_BIT:0]          genis_a, genis_b;
  logic signed [CARPIM_BIT-1:0] carpim;
  logic signed [ACC_BIT-1:0]  lane_toplam_c;
  logic [VERI_BIT-1:0]        doyum_c;

  // Handshake and issue-window computation
  always_comb begin
    min_c   = (count_x < count_w) ? count_x : count_w;
    kalan_c = min_c - istek;
    k_c     = (kalan_c > SERIT_S) ? SERIT_S : kalan_c;
    islem_hazir_o = !((islem_kod_i == KOD_RUN) &&
                      ((sonuc_say != min_c) || (|pipe_gecerli)));
    kabul_c     = islem_gecerli_i && islem_hazir_o;
    clr_kabul_c = kabul_c && ((islem_kod_i == KOD_CLRX) || (islem_kod_i == KOD_CLRW));
  end

  // Lane products summed; lanes at or above k contribute nothing
  always_comb begin
    lane_toplam_c = '0;
    okuma_idx     = '0;
    genis_a       = '0;
    genis_b       = '0;
    carpim        = '0;
    for (int j = 0; j < SERIT; j++) begin
      okuma_idx = IDX_BIT'(istek + SAYAC_BIT'(j));
      genis_a   = {isaretli_mod & buf_x[okuma_idx][VERI_BIT-1], buf_x[okuma_idx]};
      genis_b   = {isaretli_mod & buf_w[okuma_idx][VERI_BIT-1], buf_w[okuma_idx]};
      carpim    = CARPIM_BIT'($signed(genis_a)) * CARPIM_BIT'($signed(genis_b));
      if (SAYAC_BIT'(j) < k_c)
        lane_toplam_c = lane_toplam_c + ACC_BIT'(carpim);
    end
  end

  // Result clamp (or plain truncation when saturation is disabled)
  always_comb begin
    doyum_c = acc[VERI_BIT-1:0];
    if (DOYUM != 0) begin
      if (isaretli_mod) begin
        if (acc > S_MAX)      doyum_c = {1'b0, {(VERI_BIT-1){1'b1}}};
        else if (acc < S_MIN) doyum_c = {1'b1, {(VERI_BIT-1){1'b0}}};
      end else begin
        if (acc[ACC_BIT-1])   doyum_c = '0;
        else if (acc > U_MAX) doyum_c = '1;
      end
    end
  end

  // Vector buffers; contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    if (kabul_c) begin
      case (islem_kod_i)
        KOD_LDX_OP1, KOD_LDX_ALL: begin
          if (count_x < DOLU) buf_x[IDX_BIT'(count_x)] <= islec1_i;
          if (islem_kod_i == KOD_LDX_ALL && count_x < BIR_EKSIK)
            buf_x[IDX_BIT'(count_x + 1'b1)] <= islec2_i;
        end
        KOD_LDW_OP1, KOD_LDW_ALL: begin
          if (count_w < DOLU) buf_w[IDX_BIT'(count_w)] <= islec1_i;
          if (islem_kod_i == KOD_LDW_ALL && count_w < BIR_EKSIK)
            buf_w[IDX_BIT'(count_w + 1'b1)] <= islec2_i;
        end
        default: ;
      endcase
    end
  end

  // Multiplier pipeline payload
  always_ff @(posedge clk_i) begin
    pipe_toplam[0] <= lane_toplam_c;
    pipe_k[0]      <= k_c;
    for (int i = 1; i < CARPICI_GECIKME; i++) begin
      pipe_toplam[i] <= pipe_toplam[i-1];
      pipe_k[i]      <= pipe_k[i-1];
    end
  end

  // Control state, accumulator and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_x         <= '0;
      count_w         <= '0;
      istek           <= '0;
      sonuc_say       <= '0;
      acc             <= '0;
      pipe_gecerli    <= '0;
      isaretli_mod    <= 1'b0;
      tasma_o         <= 1'b0;
      sonuc_o         <= '0;
      sonuc_gecerli_o <= 1'b0;
    end else begin
      sonuc_gecerli_o <= 1'b0;
      if (clr_kabul_c) begin
        if (islem_kod_i == KOD_CLRX) count_x <= '0;
        else                         count_w <= '0;
        istek        <= '0;
        sonuc_say    <= '0;
        acc          <= '0;
        pipe_gecerli <= '0;
        isaretli_mod <= isaretli_i;
        tasma_o      <= 1'b0;
      end else begin
        istek           <= istek + k_c;
        pipe_gecerli[0] <= (k_c != '0);
        for (int i = 1; i < CARPICI_GECIKME; i++)
          pipe_gecerli[i] <= pipe_gecerli[i-1];
        if (pipe_gecerli[CARPICI_GECIKME-1]) begin
          acc       <= acc + pipe_toplam[CARPICI_GECIKME-1];
          sonuc_say <= sonuc_say + pipe_k[CARPICI_GECIKME-1];
        end
        if (kabul_c) begin
          case (islem_kod_i)
            KOD_LDX_OP1: begin
              if (count_x < DOLU) count_x <= count_x + 1'b1;
              else                tasma_o <= 1'b1;
            end
            KOD_LDX_ALL: begin
              if (count_x < BIR_EKSIK) count_x <= count_x + SAYAC_BIT'(2);
              else if (count_x == BIR_EKSIK) begin
                count_x <= DOLU;
                tasma_o <= 1'b1;
              end else tasma_o <= 1'b1;
            end
            KOD_LDW_OP1: begin
              if (count_w < DOLU) count_w <= count_w + 1'b1;
              else                tasma_o <= 1'b1;
            end
            KOD_LDW_ALL: begin
              if (count_w < BIR_EKSIK) count_w <= count_w + SAYAC_BIT'(2);
              else if (count_w == BIR_EKSIK) begin
                count_w <= DOLU;
                tasma_o <= 1'b1;
              end else tasma_o <= 1'b1;
            end
            KOD_RUN: begin
              sonuc_o         <= doyum_c;
              sonuc_gecerli_o <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vektor_carpim_hizlandirici.sv
// Directed bench for vektor_carpim_hizlandirici; a DOYUM=1 and a DOYUM=0
// instance share all inputs so saturating and truncating results are compared.
module tb_vektor_carpim_hizlandirici;

  localparam int unsigned D = 3;
  localparam logic [2:0] LDX_OP1 = 3'd0, LDX_ALL = 3'd1, LDW_OP1 = 3'd2, LDW_ALL = 3'd3;
  localparam logic [2:0] CLRX = 3'd4, CLRW = 3'd5, RUN = 3'd6, NOP = 3'd7;

  logic        clk = 1'b0, rst = 1'b1, gecerli = 1'b0, isaretli = 1'b0;
  logic [2:0]  kod = NOP;
  logic [31:0] islec1 = '0, islec2 = '0;
  logic        hazir_d, sg_d, tasma_d, hazir_k, sg_k, tasma_k;
  logic [31:0] sonuc_d, sonuc_k;
  int          total = 0, bad = 0, st = 0;

  always #5 clk = ~clk;

  vektor_carpim_hizlandirici #(.VERI_BIT(32), .DERINLIK(16), .SERIT(2),
                               .CARPICI_GECIKME(D), .DOYUM(1)) dut_d (
    .clk_i(clk), .rst_i(rst), .islem_gecerli_i(gecerli), .islem_hazir_o(hazir_d),
    .islem_kod_i(kod), .isaretli_i(isaretli), .islec1_i(islec1), .islec2_i(islec2),
    .sonuc_o(sonuc_d), .sonuc_gecerli_o(sg_d), .tasma_o(tasma_d));

  vektor_carpim_hizlandirici #(.VERI_BIT(32), .DERINLIK(16), .SERIT(2),
                               .CARPICI_GECIKME(D), .DOYUM(0)) dut_k (
    .clk_i(clk), .rst_i(rst), .islem_gecerli_i(gecerli), .islem_hazir_o(hazir_k),
    .islem_kod_i(kod), .isaretli_i(isaretli), .islec1_i(islec1), .islec2_i(islec2),
    .sonuc_o(sonuc_k), .sonuc_gecerli_o(sg_k), .tasma_o(tasma_k));

  // Drive one command and hold it until accepted; returns #1 after the accepting edge
  task automatic komut(input logic [2:0] k, input logic s, input logic [31:0] a,
                       input logic [31:0] b, output int stall);
    bit done = 1'b0;
    kod = k; isaretli = s; islec1 = a; islec2 = b; gecerli = 1'b1; stall = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (hazir_d) done = 1'b1;
      else stall++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL handshake kod=%0d: hazir stayed 0 for 200 cycles", k);
    end else begin
      @(posedge clk); #1;
    end
    gecerli = 1'b0; kod = NOP;
  endtask

  task automatic clr_both(input logic s);
    komut(CLRX, s, 0, 0, st);
    komut(CLRW, s, 0, 0, st);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (sonuc_d !== 32'd0) begin bad++; $display("FAIL reset_sonuc got=%h want=0", sonuc_d); end
    total++; if (sg_d !== 1'b0) begin bad++; $display("FAIL reset_gecerli got=%b want=0", sg_d); end
    total++; if (tasma_d !== 1'b0) begin bad++; $display("FAIL reset_tasma got=%b want=0", tasma_d); end
    rst = 1'b0;
    kod = RUN; gecerli = 1'b1;
    @(negedge clk);
    total++; if (hazir_d !== 1'b1) begin bad++; $display("FAIL reset_run_hazir got=%b want=1", hazir_d); end
    @(posedge clk); #1;
    gecerli = 1'b0; kod = NOP;
    total++; if (sg_d !== 1'b1 || sonuc_d !== 32'd0) begin
      bad++; $display("FAIL reset_run_sonuc got=%b/%h want=1/0", sg_d, sonuc_d); end
    @(posedge clk); #1;
    total++; if (sg_d !== 1'b0) begin bad++; $display("FAIL reset_run_pulse got=%b want=0", sg_d); end
  endtask

  task automatic test_unsigned;
    clr_both(1'b0);
    komut(LDX_ALL, 0, 1, 2, st);
    komut(LDX_ALL, 0, 3, 4, st);
    komut(LDW_ALL, 0, 5, 6, st);
    komut(LDW_ALL, 0, 7, 8, st);
    komut(RUN, 0, 0, 0, st);
    total++; if (st == 0 || st > D + 2) begin bad++; $display("FAIL unsigned_stall got=%0d want=1..%0d", st, D + 2); end
    total++; if (sg_d !== 1'b1 || sonuc_d !== 32'd70) begin
      bad++; $display("FAIL unsigned_sonuc got=%b/%0d want=1/70", sg_d, sonuc_d); end
    total++; if (sonuc_k !== 32'd70) begin bad++; $display("FAIL unsigned_trunc got=%0d want=70", sonuc_k); end
  endtask

  task automatic test_signed;
    clr_both(1'b1);
    komut(LDX_ALL, 1, 32'hFFFF_FFFD, 32'd2, st);
    komut(LDW_ALL, 1, 32'd4, 32'hFFFF_FFFB, st);
    komut(RUN, 1, 0, 0, st);
    total++; if (sg_d !== 1'b1 || sonuc_d !== 32'hFFFF_FFEA) begin
      bad++; $display("FAIL signed_sonuc got=%b/%h want=1/ffffffea", sg_d, sonuc_d); end
    total++; if (sonuc_k !== 32'hFFFF_FFEA) begin bad++; $display("FAIL signed_trunc got=%h want=ffffffea", sonuc_k); end
  endtask

  task automatic test_saturation;
    clr_both(1'b1);
    komut(LDX_ALL, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, st);
    komut(LDW_ALL, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, st);
    komut(RUN, 1, 0, 0, st);
    total++; if (sonuc_d !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_pos got=%h want=7fffffff", sonuc_d); end
    total++; if (sonuc_k !== 32'h0000_0002) begin bad++; $display("FAIL trunc_pos got=%h want=00000002", sonuc_k); end
    clr_both(1'b1);
    komut(LDX_ALL, 1, 32'h8000_0000, 32'h8000_0000, st);
    komut(LDW_ALL, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, st);
    komut(RUN, 1, 0, 0, st);
    total++; if (sonuc_d !== 32'h8000_0000) begin bad++; $display("FAIL sat_neg got=%h want=80000000", sonuc_d); end
    total++; if (sonuc_k !== 32'h0000_0000) begin bad++; $display("FAIL trunc_neg got=%h want=00000000", sonuc_k); end
    clr_both(1'b0);
    komut(LDX_ALL, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
    komut(LDW_ALL, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
    komut(RUN, 0, 0, 0, st);
    total++; if (sonuc_d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_uns got=%h want=ffffffff", sonuc_d); end
    total++; if (sonuc_k !== 32'h0000_0002) begin bad++; $display("FAIL trunc_uns got=%h want=00000002", sonuc_k); end
  endtask

  task automatic test_overflow;
    clr_both(1'b0);
    for (int i = 0; i < 16; i++) komut(LDX_OP1, 0, 32'(i + 1), 0, st);
    total++; if (tasma_d !== 1'b0) begin bad++; $display("FAIL ovf_full_noflag got=%b want=0", tasma_d); end
    komut(LDX_OP1, 0, 32'd99, 0, st);
    total++; if (tasma_d !== 1'b1) begin bad++; $display("FAIL ovf_x_flag got=%b want=1", tasma_d); end
    komut(CLRW, 0, 0, 0, st);
    total++; if (tasma_d !== 1'b0) begin bad++; $display("FAIL ovf_clrw_clear got=%b want=0", tasma_d); end
    for (int i = 0; i < 15; i++) komut(LDW_OP1, 0, 32'd1, 0, st);
    total++; if (tasma_d !== 1'b0) begin bad++; $display("FAIL ovf_w15_noflag got=%b want=0", tasma_d); end
    komut(LDW_ALL, 0, 32'd1, 32'd100, st);
    total++; if (tasma_d !== 1'b1) begin bad++; $display("FAIL ovf_w_all_flag got=%b want=1", tasma_d); end
    komut(RUN, 0, 0, 0, st);
    total++; if (sg_d !== 1'b1 || sonuc_d !== 32'd136) begin
      bad++; $display("FAIL ovf_sonuc got=%b/%0d want=1/136", sg_d, sonuc_d); end
    komut(CLRX, 0, 0, 0, st);
    total++; if (tasma_d !== 1'b0) begin bad++; $display("FAIL ovf_clrx_clear got=%b want=0", tasma_d); end
  endtask

  task automatic test_clr_in_flight;
    clr_both(1'b0);
    komut(LDX_ALL, 0, 32'd3, 32'd5, st);
    komut(LDW_ALL, 0, 32'd7, 32'd9, st);
    komut(NOP, 0, 0, 0, st);
    komut(CLRW, 0, 0, 0, st);
    komut(LDW_OP1, 0, 32'd2, 0, st);
    komut(RUN, 0, 0, 0, st);
    total++; if (sg_d !== 1'b1 || sonuc_d !== 32'd6) begin
      bad++; $display("FAIL clr_flight_sonuc got=%b/%0d want=1/6", sg_d, sonuc_d); end
  endtask

  task automatic test_back_to_back;
    clr_both(1'b0);
    komut(LDX_ALL, 0, 32'd1, 32'd2, st);
    komut(LDW_ALL, 0, 32'd3, 32'd4, st);
    komut(RUN, 0, 0, 0, st);
    total++; if (sonuc_d !== 32'd11) begin bad++; $display("FAIL b2b_first got=%0d want=11", sonuc_d); end
    komut(RUN, 0, 0, 0, st);
    total++; if (sg_d !== 1'b1 || sonuc_d !== 32'd11 || st != 0) begin
      bad++; $display("FAIL b2b_repeat got=%b/%0d stall=%0d want=1/11 stall=0", sg_d, sonuc_d, st); end
    komut(LDX_OP1, 0, 32'd5, 0, st);
    komut(LDW_OP1, 0, 32'd6, 0, st);
    komut(RUN, 0, 0, 0, st);
    total++; if (sonuc_d !== 32'd41) begin bad++; $display("FAIL b2b_extend got=%0d want=41", sonuc_d); end
  endtask

  task automatic test_reset_mid_run;
    clr_both(1'b0);
    komut(LDX_ALL, 0, 32'd1, 32'd2, st);
    komut(LDW_ALL, 0, 32'd3, 32'd4, st);
    komut(NOP, 0, 0, 0, st);
    #2 rst = 1'b1;
    #2;
    total++; if (sg_d !== 1'b0 || tasma_d !== 1'b0) begin
      bad++; $display("FAIL midrst_async got=%b/%b want=0/0", sg_d, tasma_d); end
    @(negedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++; if (sg_d !== 1'b0) begin bad++; $display("FAIL midrst_no_pulse cyc=%0d got=%b want=0", i, sg_d); end
    end
    komut(RUN, 0, 0, 0, st);
    total++; if (sg_d !== 1'b1 || sonuc_d !== 32'd0 || st != 0) begin
      bad++; $display("FAIL midrst_run got=%b/%0d stall=%0d want=1/0 stall=0", sg_d, sonuc_d, st); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_saturation();
    test_overflow();
    test_clr_in_flight();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
